// File: rtl/grid_sequencer_pkg.sv
// Shared widths, ASCII constants and FSM state type for the beam-grid sequencer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package grid_sequencer_pkg;

    localparam int unsigned RESULT_WIDTH = `DATA_WIDTH + 8;

    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CARET = 8'h5E;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    typedef enum logic [1:0] {
        RUN,
        PAD,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/grid_sequencer.sv
// Streams an ASCII beam grid into the splitter rotation, pads short rows, then drains
// one full rotation to total the final-row timeline counts.
module grid_sequencer
    import grid_sequencer_pkg::*;
#(
    parameter int unsigned LINE_LENGTH = 141
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    split_en,
    output logic                    split_out,
    input  logic [`DATA_WIDTH-1:0]  count_in,
    output logic [RESULT_WIDTH-1:0] result,
    output logic [31:0]             split_count,
    output logic                    result_valid,
    output logic                    error
);

    localparam int unsigned   CW      = $clog2(LINE_LENGTH + 1);
    localparam logic [CW-1:0] COL_END = CW'(LINE_LENGTH);
    localparam logic [CW-1:0] COL_MID = CW'(LINE_LENGTH / 2);

    state_e                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic                    last_q, last_d;
    logic                    split_en_q, split_en_d;
    logic                    split_out_q, split_out_d;
    logic                    drain_q, drain_d;
    logic                    error_q, error_d;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
    logic [31:0]             split_count_q, split_count_d;
    logic                    byte_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            col_q         <= '0;
            last_q        <= 1'b0;
            split_en_q    <= 1'b0;
            split_out_q   <= 1'b0;
            drain_q       <= 1'b0;
            error_q       <= 1'b0;
            result_q      <= '0;
            split_count_q <= '0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            last_q        <= last_d;
            split_en_q    <= split_en_d;
            split_out_q   <= split_out_d;
            drain_q       <= drain_d;
            error_q       <= error_d;
            result_q      <= result_d;
            split_count_q <= split_count_d;
        end
    end

    // Step strobes are registered, so a PAD/DRAIN pulse issued in the last column shows
    // up one cycle later; both states therefore spend one extra cycle at COL_END.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        last_d      = last_q;
        error_d     = error_q;
        split_en_d  = 1'b0;
        split_out_d = 1'b0;
        drain_d     = 1'b0;
        byte_ok     = 1'b0;

        case (state_q)
            RUN: begin
                if (in_valid) begin
                    if (in_data == ASCII_LF) begin
                        if (col_q == COL_END) begin
                            col_d = '0;
                        end else begin
                            error_d    = 1'b1;
                            split_en_d = 1'b1;
                            col_d      = col_q + 1'b1;
                            last_d     = in_last;
                            state_d    = PAD;
                        end
                    end else if (in_data != ASCII_CR) begin
                        if (col_q == COL_END) begin
                            error_d = 1'b1;
                        end else begin
                            byte_ok = (in_data == ASCII_DOT) || (in_data == ASCII_CARET) ||
                                      ((in_data == ASCII_S) && (col_q == COL_MID));
                            if (!byte_ok) begin
                                error_d = 1'b1;
                            end
                            split_en_d  = 1'b1;
                            split_out_d = (in_data == ASCII_CARET);
                            col_d       = col_q + 1'b1;
                        end
                    end

                    // Final byte closes its row like a newline before draining.
                    if (in_last && (state_d == RUN)) begin
                        if ((col_d == '0) || (col_d == COL_END)) begin
                            col_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            error_d = 1'b1;
                            last_d  = 1'b1;
                            state_d = PAD;
                        end
                    end
                end
            end

            PAD: begin
                if (col_q == COL_END) begin
                    col_d   = '0;
                    last_d  = 1'b0;
                    state_d = last_q ? DRAIN : RUN;
                end else begin
                    split_en_d = 1'b1;
                    col_d      = col_q + 1'b1;
                end
            end

            DRAIN: begin
                if (col_q == COL_END) begin
                    col_d   = '0;
                    state_d = DONE;
                end else begin
                    split_en_d = 1'b1;
                    drain_d    = 1'b1;
                    col_d      = col_q + 1'b1;
                end
            end

            default: begin
                state_d = DONE;
            end
        endcase

        result_d = drain_q ? (result_q + RESULT_WIDTH'(count_in)) : result_q;

        split_count_d = split_count_q;
        if (split_en_q && split_out_q && (count_in != '0)) begin
            split_count_d = split_count_q + 32'd1;
        end
    end

    always_comb begin
        in_ready     = (state_q == RUN);
        result_valid = (state_q == DONE);
        split_en     = split_en_q;
        split_out    = split_out_q;
        result       = result_q;
        split_count  = split_count_q;
        error        = error_q;
    end

endmodule

// File: tb/tb_grid_sequencer.sv
// Directed bench for grid_sequencer with LINE_LENGTH=5 and a behavioural splitter rotation.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_grid_sequencer;
    import grid_sequencer_pkg::*;

    localparam int unsigned LL = 5;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic [7:0]              in_data = 8'h00;
    logic                    in_last = 1'b0;
    logic                    in_ready;
    logic                    split_en;
    logic                    split_out;
    logic [`DATA_WIDTH-1:0]  count_in;
    logic [RESULT_WIDTH-1:0] result;
    logic [31:0]             split_count;
    logic                    result_valid;
    logic                    error;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned pulses = 0;
    int unsigned idle_pulses = 0;
    int unsigned snap;

    grid_sequencer #(.LINE_LENGTH(LL)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .split_en    (split_en),
        .split_out   (split_out),
        .count_in    (count_in),
        .result      (result),
        .split_count (split_count),
        .result_valid(result_valid),
        .error       (error)
    );

    always #5 clock = ~clock;

    // Splitter: a rotation of per-column timeline counts, one timeline starting under 'S'.
    logic [`DATA_WIDTH-1:0] cnt [LL];
    int unsigned            ptr = 0;

    assign count_in = cnt[ptr];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LL; i++) cnt[i] <= (i == LL / 2) ? `DATA_WIDTH'(1) : '0;
            ptr <= 0;
        end else if (split_en) begin
            if (split_out) begin
                cnt[ptr] <= '0;
                if (ptr > 0)      cnt[ptr-1] <= cnt[ptr-1] + cnt[ptr];
                if (ptr < LL - 1) cnt[ptr+1] <= cnt[ptr+1] + cnt[ptr];
            end
            ptr <= (ptr == LL - 1) ? 0 : ptr + 1;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            pulses      <= 0;
            idle_pulses <= 0;
        end else if (split_en) begin
            pulses <= pulses + 1;
            if (!in_ready) idle_pulses <= idle_pulses + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input bit rnd);
        int unsigned gap;
        gap = rnd ? $urandom_range(0, 2) : 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'h58;
            in_last  = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        for (int k = 0; k < 64; k++) begin
            if (in_ready) begin
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        chk("accept_timeout", 64'(in_ready), 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last, input bit rnd);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1), rnd);
    endtask

    task automatic check_done(input string name, input logic [63:0] er, input logic [63:0] esc,
                              input logic ee, input int unsigned ep, input bit chk_err);
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (result_valid) break;
        end
        chk({name, ".valid"}, 64'(result_valid), 1);
        chk({name, ".result"}, 64'(result), er);
        chk({name, ".splits"}, 64'(split_count), esc);
        if (chk_err) chk({name, ".error"}, 64'(error), 64'(ee));
        repeat (3) @(negedge clock);
        #1;
        chk({name, ".hold_result"}, 64'(result), er);
        chk({name, ".done_split_en"}, 64'(split_en), 0);
        chk({name, ".done_ready"}, 64'(in_ready), 0);
        chk({name, ".pulses"}, 64'(pulses), 64'(ep));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst.in_ready", 64'(in_ready), 1);
        chk("rst.split_en", 64'(split_en), 0);
        chk("rst.split_out", 64'(split_out), 0);
        chk("rst.result", 64'(result), 0);
        chk("rst.split_count", 64'(split_count), 0);
        chk("rst.result_valid", 64'(result_valid), 0);
        chk("rst.error", 64'(error), 0);

        send_str("..S..\n.....\n", 1, 0);
        check_done("plain", 1, 0, 1'b0, 15, 1);

        do_reset();
        send_str("..S..\n..^..\n", 1, 0);
        check_done("one_split", 2, 1, 1'b0, 15, 1);

        do_reset();
        send_str("..S..\n..^..\n.^.^.\n", 1, 0);
        check_done("three_split", 4, 3, 1'b0, 20, 1);

        do_reset();
        send_str("..S..\n..", 0, 0);
        snap = idle_pulses;
        send_str("\n.", 0, 0);
        chk("short.pad_pulses", 64'(idle_pulses - snap), 3);
        send_str("....\n", 1, 0);
        check_done("short", 1, 0, 1'b1, 20, 1);

        do_reset();
        send_str("..S..\n.S^..\n", 1, 0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("drain3.split_en", 64'(split_en), 1);
        chk("drain3.in_ready", 64'(in_ready), 0);
        chk("drain3.split_count", 64'(split_count), 1);
        chk("drain3.error", 64'(error), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst.in_ready", 64'(in_ready), 1);
        chk("midrst.split_en", 64'(split_en), 0);
        chk("midrst.split_out", 64'(split_out), 0);
        chk("midrst.result", 64'(result), 0);
        chk("midrst.split_count", 64'(split_count), 0);
        chk("midrst.result_valid", 64'(result_valid), 0);
        chk("midrst.error", 64'(error), 0);
        reset = 1'b0;

        do_reset();
        send_str("..S..\015\n..^..\n", 1, 1);
        check_done("cr_gaps", 2, 1, 1'b0, 15, 1);

        do_reset();
        send_str("..S...\n..^..\n", 1, 0);
        check_done("overlong", 2, 1, 1'b1, 15, 1);

        do_reset();
        send_str("..S..\n..^..", 1, 0);
        check_done("last_on_grid", 2, 1, 1'b0, 15, 1);

        do_reset();
        send_str("..S..\n..^", 1, 0);
        check_done("last_short", 2, 1, 1'b1, 15, 0);

        do_reset();
        send_str(".S...\n.....\n", 1, 0);
        check_done("bad_s", 1, 0, 1'b1, 15, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
